ins_aligner: RTL and testbench
==============================

# ins_aligner

Instruction-stream aligner between the fetch port and the compressed-instruction decoder. It accepts 32-bit word-aligned fetch words, splits and re-joins 16-bit parcels so that every RVC instruction and every 32-bit instruction, aligned or halfword-straddling, is presented as one raw 32-bit instruction with its PC. Output is registered behind a valid/ready handshake. Expansion of compressed parcels is done downstream by the decoder, not here.

## Interface
- RESET_PC, 32'h0000_0000: PC of first instruction after reset; bit 0 ignored.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_valid  in  1  fetch_data valid
- fetch_data  in  32  word at word-aligned address; parcel 0 = [15:0], parcel 1 = [31:16]
- fetch_ready  out  1  aligner consumes fetch_data this cycle when high with fetch_valid
- redirect_valid  in  1  flush and restart at redirect_pc (branch/jump/trap)
- redirect_pc  in  32  new PC; bit 0 treated as 0
- ins_valid  out  1  ins_data/ins_pc/ins_is_c valid
- ins_ready  in  1  consumer accepts this cycle
- ins_data  out  32  raw instruction; compressed parcels zero-extended to 32 bits
- ins_pc  out  32  PC of ins_data
- ins_is_c  out  1  ins_data[1:0] != 2'b11

## Operation
- State machine (align_state): EMPTY (no pending parcel), HALF (one pending parcel in pend_q), SKIP (next word's parcel 0 discarded, target at pc[1]=1).
- Registers: pc_q (next instruction PC), pend_q[15:0], output register (ins_valid/ins_data/ins_pc/ins_is_c).
- out_free = !ins_valid || ins_ready. No state change when out_free=0 (except redirect).
- fetch_ready = out_free && !redirect_valid && (state==EMPTY || state==SKIP || (state==HALF && pend_q[1:0]==2'b11)).
- EMPTY, word accepted: parcel0[1:0]!=11 -> emit {16'h0,parcel0} @pc_q, pend_q<=parcel1, pc_q+=2, ->HALF; else emit full word @pc_q, pc_q+=4, stay EMPTY.
- HALF, pend_q compressed: emit {16'h0,pend_q} @pc_q without consuming fetch, pc_q+=2, ->EMPTY.
- HALF, pend_q 32-bit, word accepted: emit {parcel0,pend_q} @pc_q, pend_q<=parcel1, pc_q+=4, stay HALF.
- SKIP, word accepted: pend_q<=parcel1, ->HALF, no emission that cycle.
- Redirect (highest priority): ins_valid<=0, pend_q dropped, pc_q<=redirect_pc&~1, state<=redirect_pc[1]?SKIP:EMPTY. fetch_data in same cycle ignored. Fetch unit is flushed by the same redirect; words after it belong to the new stream.
- pc_q arithmetic is 32-bit modulo; wrap from 32'hFFFF_FFFE to 0 without flag.

## Timing
- Reset: ins_valid=0, ins_data=0, ins_pc=0, ins_is_c=0, pend_q=0, pc_q=RESET_PC&~1, state=RESET_PC[1]?SKIP:EMPTY; fetch_ready follows combinationally (1 after reset).
- Latency: accepted word -> instruction on ins_* next cycle; pending compressed parcel emitted one cycle after prior emission accepted.
- Throughput: one instruction per cycle with ins_ready=1; two compressed parcels in one word need one fetch and two cycles.
- ins_* hold stable while ins_valid && !ins_ready.
- Reset asserted mid-operation: immediate return to reset values, pending parcel lost.
- Redirect with ins_valid && !ins_ready: output dropped anyway.

## Structure
- Shared package: align_state enum (EMPTY, HALF, SKIP), parcel width constant 16, is_compressed(parcel) function (parcel[1:0]!=2'b11), reused by decoder and fetch logic.
- Single module, no sub-module; output register inline.

## Test plan
- Reset, RESET_PC=0, word 32'h00A0_0513 -> ins_data 32'h00A0_0513, ins_pc 0, ins_is_c 0; next pc_q 4.
- Word 32'h0505_4501 -> 32'h0000_4501 @0 then 32'h0000_0505 @2; exactly one fetch handshake, fetch_ready low in second cycle.
- Words 32'h0513_4501, 32'h4501_00A0 -> 32'h0000_4501 @0, 32'h00A0_0513 @2 (straddle), 32'h0000_4501 @6.
- redirect_pc 32'h0000_0102, word 32'h4505_FFFF -> parcel 0 dropped, 32'h0000_4505 @32'h102.
- ins_ready low 3 cycles during straddle sequence -> ins_* stable, fetch_ready 0, no parcel lost after release.
- rst_n pulsed low while in HALF -> ins_valid 0 asynchronously, state/pc_q back to reset values, next word decoded from RESET_PC.

Source files
------------

// File: rtl/ins_aligner_pkg.sv
// Shared alignment types and parcel helpers for the fetch/decode boundary.
// Used by the aligner, decoder and fetch logic.
package ins_aligner_pkg;

    localparam int PARCEL_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        SKIP  = 2'd2
    } align_state_e;

    function automatic logic is_compressed(
        input logic [PARCEL_W-1:0] parcel
    );
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/ins_aligner.sv
// Splits word-aligned fetch words into 16/32-bit instructions,
// re-joining straddling 32-bit instructions across words.
module ins_aligner
    import ins_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    output logic        ins_is_c
);

    localparam logic [31:0] RST_PC = RESET_PC & ~32'h1;
    localparam align_state_e RST_STATE =
        RESET_PC[1] ? SKIP : EMPTY;

    align_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [PARCEL_W-1:0] pend_q, pend_d;
    logic        valid_d;
    logic [31:0] data_d;
    logic [31:0] ipc_d;
    logic        out_free;
    logic        fire;
    logic        pend_c;
    logic [PARCEL_W-1:0] p0, p1;

    assign p0       = fetch_data[15:0];
    assign p1       = fetch_data[31:16];
    assign pend_c   = is_compressed(pend_q);
    assign out_free = !ins_valid || ins_ready;
    // A compressed pending parcel drains without needing a new word.
    assign fetch_ready = out_free && !redirect_valid &&
        (state_q != HALF || !pend_c);
    assign fire = fetch_valid && fetch_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        valid_d = ins_valid;
        data_d  = ins_data;
        ipc_d   = ins_pc;
        if (redirect_valid) begin
            valid_d = 1'b0;
            pend_d  = '0;
            pc_d    = redirect_pc & ~32'h1;
            state_d = redirect_pc[1] ? SKIP : EMPTY;
        end else if (out_free) begin
            valid_d = 1'b0;
            unique case (state_q)
                EMPTY: if (fire) begin
                    valid_d = 1'b1;
                    ipc_d   = pc_q;
                    if (is_compressed(p0)) begin
                        data_d  = {16'h0, p0};
                        pend_d  = p1;
                        pc_d    = pc_q + 32'd2;
                        state_d = HALF;
                    end else begin
                        data_d = fetch_data;
                        pc_d   = pc_q + 32'd4;
                    end
                end
                HALF: if (pend_c) begin
                    valid_d = 1'b1;
                    ipc_d   = pc_q;
                    data_d  = {16'h0, pend_q};
                    pc_d    = pc_q + 32'd2;
                    state_d = EMPTY;
                end else if (fire) begin
                    valid_d = 1'b1;
                    ipc_d   = pc_q;
                    data_d  = {p0, pend_q};
                    pend_d  = p1;
                    pc_d    = pc_q + 32'd4;
                end
                SKIP: if (fire) begin
                    pend_d  = p1;
                    state_d = HALF;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            pc_q      <= RST_PC;
            pend_q    <= '0;
            ins_valid <= 1'b0;
            ins_data  <= '0;
            ins_pc    <= '0;
            ins_is_c  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            ins_valid <= valid_d;
            ins_data  <= data_d;
            ins_pc    <= ipc_d;
            ins_is_c  <= is_compressed(data_d[15:0]);
        end
    end

endmodule

// File: tb/tb_ins_aligner.sv
// Directed and randomized checks of the instruction aligner against
// a halfword-memory walk model.
module tb_ins_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        fetch_ready;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_is_c;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    ins_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .ins_is_c       (ins_is_c)
    );

    // Drive one cycle's inputs at the falling edge, then settle.
    task automatic step(input logic fv, input logic [31:0] fd,
                        input logic ir, input logic rv,
                        input logic [31:0] rp);
        @(negedge clk);
        fetch_valid    = fv;
        fetch_data     = fd;
        ins_ready      = ir;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({ins_valid, ins_data, ins_pc, ins_is_c} !== 66'h0) begin
            $display("FAIL reset_out: got v=%0b d=%h pc=%h c=%0b want 0",
                     ins_valid, ins_data, ins_pc, ins_is_c);
        end else passes++;
        checks++;
        if (fetch_ready !== 1'b1) begin
            $display("FAIL reset_fready: got %0b want 1", fetch_ready);
        end else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_word;
        step(1, 32'h00A0_0513, 1, 0, 0);
        checks++;
        if (fetch_ready !== 1'b1) begin
            $display("FAIL word_fready: got %0b want 1", fetch_ready);
        end else passes++;
        step(1, 32'h00A0_0513, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc, ins_is_c} !==
            {1'b1, 32'h00A0_0513, 32'h0, 1'b0}) begin
            $display("FAIL word_out: got v=%0b d=%h pc=%h c=%0b want 1 00a00513 0 0",
                     ins_valid, ins_data, ins_pc, ins_is_c);
        end else passes++;
        step(0, 0, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc} !==
            {1'b1, 32'h00A0_0513, 32'h4}) begin
            $display("FAIL word_pc4: got v=%0b d=%h pc=%h want pc 4",
                     ins_valid, ins_data, ins_pc);
        end else passes++;
    endtask

    task automatic test_two_compressed;
        step(0, 0, 1, 1, 32'h0);
        step(1, 32'h0505_4501, 1, 0, 0);
        step(1, 32'hDEAD_BEEF, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc, ins_is_c, fetch_ready} !==
            {1'b1, 32'h0000_4501, 32'h0, 1'b1, 1'b0}) begin
            $display("FAIL twoc_first: got v=%0b d=%h pc=%h c=%0b fr=%0b",
                     ins_valid, ins_data, ins_pc, ins_is_c, fetch_ready);
        end else passes++;
        step(0, 0, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc, ins_is_c} !==
            {1'b1, 32'h0000_0505, 32'h2, 1'b1}) begin
            $display("FAIL twoc_second: got v=%0b d=%h pc=%h c=%0b",
                     ins_valid, ins_data, ins_pc, ins_is_c);
        end else passes++;
        step(0, 0, 1, 0, 0);
        checks++;
        if (ins_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            $display("FAIL twoc_onefetch: got v=%0b fr=%0b want 0 1",
                     ins_valid, fetch_ready);
        end else passes++;
    endtask

    task automatic test_straddle(input int stall);
        step(0, 0, 1, 1, 32'h0);
        step(1, 32'h0513_4501, 1, 0, 0);
        step(1, 32'h4501_00A0, stall == 0, 0, 0);
        for (int i = 1; i <= stall; i++) begin
            checks++;
            if ({ins_valid, ins_data, ins_pc, fetch_ready} !==
                {1'b1, 32'h0000_4501, 32'h0, 1'b0}) begin
                $display("FAIL stall_hold%0d: got v=%0b d=%h pc=%h fr=%0b",
                         i, ins_valid, ins_data, ins_pc, fetch_ready);
            end else passes++;
            step(1, 32'h4501_00A0, i == stall, 0, 0);
        end
        checks++;
        if ({ins_valid, ins_data, ins_pc} !==
            {1'b1, 32'h0000_4501, 32'h0}) begin
            $display("FAIL strad_a: got v=%0b d=%h pc=%h want 4501 @0",
                     ins_valid, ins_data, ins_pc);
        end else passes++;
        step(0, 0, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc, ins_is_c} !==
            {1'b1, 32'h00A0_0513, 32'h2, 1'b0}) begin
            $display("FAIL strad_b: got v=%0b d=%h pc=%h c=%0b want 00a00513 @2",
                     ins_valid, ins_data, ins_pc, ins_is_c);
        end else passes++;
        step(0, 0, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc, ins_is_c} !==
            {1'b1, 32'h0000_4501, 32'h6, 1'b1}) begin
            $display("FAIL strad_c: got v=%0b d=%h pc=%h c=%0b want 4501 @6",
                     ins_valid, ins_data, ins_pc, ins_is_c);
        end else passes++;
    endtask

    task automatic test_redirect_skip;
        step(0, 0, 1, 1, 32'h0000_0103);
        step(1, 32'h4505_FFFF, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        checks++;
        if (ins_valid !== 1'b0) begin
            $display("FAIL skip_noemit: got v=%0b want 0", ins_valid);
        end else passes++;
        step(0, 0, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc, ins_is_c} !==
            {1'b1, 32'h0000_4505, 32'h102, 1'b1}) begin
            $display("FAIL skip_out: got v=%0b d=%h pc=%h c=%0b want 4505 @102",
                     ins_valid, ins_data, ins_pc, ins_is_c);
        end else passes++;
        step(0, 0, 1, 1, 32'hFFFF_FFFE);
        step(1, 32'h4505_0000, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 32'h00A0_0513, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc} !==
            {1'b1, 32'h0000_4505, 32'hFFFF_FFFE}) begin
            $display("FAIL wrap_a: got v=%0b d=%h pc=%h want 4505 @fffffffe",
                     ins_valid, ins_data, ins_pc);
        end else passes++;
        step(0, 0, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc} !==
            {1'b1, 32'h00A0_0513, 32'h0}) begin
            $display("FAIL wrap_b: got v=%0b d=%h pc=%h want 00a00513 @0",
                     ins_valid, ins_data, ins_pc);
        end else passes++;
    endtask

    task automatic test_reset_mid;
        step(0, 0, 1, 1, 32'h40);
        step(1, 32'h0505_4501, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ins_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            $display("FAIL rstmid_async: got v=%0b fr=%0b want 0 1",
                     ins_valid, fetch_ready);
        end else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h00A0_0513, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        checks++;
        if ({ins_valid, ins_data, ins_pc} !==
            {1'b1, 32'h00A0_0513, 32'h0}) begin
            $display("FAIL rstmid_next: got v=%0b d=%h pc=%h want 00a00513 @0",
                     ins_valid, ins_data, ins_pc);
        end else passes++;
    endtask

    // Reference: walk a halfword memory from the start PC.
    task automatic test_random(input int run);
        logic [15:0] mem [128];
        logic [31:0] base;
        logic [31:0] start;
        logic [31:0] exp_d [$];
        logic [31:0] exp_p [$];
        logic [31:0] fd;
        logic [31:0] sd, sp;
        logic        fv, ir, stalled;
        int idx, fw, got, cyc;
        base = 32'h0000_2000 + 32'(run) * 32'h400;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(1, 0) == 1) mem[i][1:0] = 2'b11;
        end
        start = base + 32'(2 * $urandom_range(3, 0));
        idx = int'((start - base) / 2);
        while (idx < 128) begin
            if (mem[idx][1:0] != 2'b11) begin
                exp_d.push_back({16'h0, mem[idx]});
                exp_p.push_back(base + 32'(2 * idx));
                idx += 1;
            end else if (idx + 1 < 128) begin
                exp_d.push_back({mem[idx + 1], mem[idx]});
                exp_p.push_back(base + 32'(2 * idx));
                idx += 2;
            end else break;
        end
        fw = int'((start - base) / 4);
        step(0, 0, 1, 1, start);
        stalled = 1'b0;
        sd = '0;
        sp = '0;
        got = 0;
        cyc = 0;
        while (got < exp_d.size() && cyc < 3000) begin
            fv = $urandom_range(3, 0) != 0;
            ir = $urandom_range(3, 0) != 0;
            fd = fw < 64 ? {mem[2 * fw + 1], mem[2 * fw]}
                         : $urandom;
            step(fv, fd, ir, 0, 0);
            if (stalled) begin
                checks++;
                if ({ins_valid, ins_data, ins_pc} !== {1'b1, sd, sp}) begin
                    $display("FAIL rnd%0d_hold: got v=%0b d=%h pc=%h want %h @%h",
                             run, ins_valid, ins_data, ins_pc, sd, sp);
                end else passes++;
            end
            if (fv && fetch_ready) fw++;
            if (ins_valid && ir) begin
                checks++;
                if ({ins_data, ins_pc, ins_is_c} !==
                    {exp_d[got], exp_p[got], exp_d[got][1:0] != 2'b11}) begin
                    $display("FAIL rnd%0d_ins%0d: got %h @%h c=%0b want %h @%h",
                             run, got, ins_data, ins_pc, ins_is_c,
                             exp_d[got], exp_p[got]);
                end else passes++;
                got++;
            end
            stalled = ins_valid && !ir;
            sd = ins_data;
            sp = ins_pc;
            cyc++;
        end
        checks++;
        if (got != exp_d.size()) begin
            $display("FAIL rnd%0d_timeout: got %0d instrs want %0d",
                     run, got, exp_d.size());
        end else passes++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_compressed();
        test_straddle(0);
        test_straddle(3);
        test_redirect_skip();
        test_reset_mid();
        for (int r = 0; r < 4; r++) test_random(r);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
